i2c_dut: RTL and testbench
==========================

// Module: i2c_dut
// PURPOSE
// - I2C target (slave) at the far end of the i2c_if "dut" modport; the UVC acts as bus master.
// - Receives address/pointer/data bytes on open-drain sda/scl and serves an internal byte register file.
// - Oversamples the bus on system_clock; the bus is never clocked directly.
// - Optional clock stretching exercises master-side stretch handling.
// PARAMETERS
// - SLAVE_ADDR      7'h3C  7-bit target address this block responds to
// - NUM_REGS        16     register file depth in bytes (power of 2, 2..256)
// - STRETCH_CYCLES  0      system_clock cycles scl is held low after each ACK/NACK slot; 0 = never stretch
// PORTS
// - system_clock  input  1  sampling/logic clock, >= 10x scl frequency
// - reset_n       input  1  asynchronous, active-low reset
// - sda           inout  1  I2C data, open-drain: drive 1'b0 or 1'bz only, never 1'b1 (bus pulls up, tri1)
// - scl           inout  1  I2C clock, open-drain: driven 1'b0 only while stretching, else 1'bz
// BEHAVIOUR
// - Reset (async on reset_n low): sda and scl released (z); state IDLE; pointer 0; all registers 8'h00.
// - Inputs: sda/scl go through 2-flop synchronisers, then a 1-cycle-delayed copy for edge detection.
// - START: sda falls while scl high. STOP: sda rises while scl high. Both are detected in every state.
// - Repeated START aborts the current byte, releases sda and enters ADDR.
// - STOP releases sda and scl and returns to IDLE.
// - Bits are sampled on scl rising edge, MSB first.
// - The slave changes sda only on the cycle after a detected scl falling edge (data hold time).
// - State machine:
//   IDLE -> ADDR on START.
//   ADDR: after 8 bits, compare [7:1] with SLAVE_ADDR. Match -> ACK; mismatch -> IGNORE (bus released until STOP/START).
//   ACK slot: sda driven 0 from the scl fall after bit 8 to the scl fall after bit 9.
//   R/W=0 -> PTR: first byte written to pointer (mod NUM_REGS); ACK; then WDATA.
//   WDATA: each byte written to reg[ptr]; ptr++ wrapping NUM_REGS-1 -> 0; ACK every byte.
//   R/W=1 -> RDATA: shift out reg[ptr] MSB first.
//   RDATA bit values: sda = 0 for a 0 bit, released for a 1 bit.
//   RDATA: ptr++ (wrap) after each byte; release sda for the master ACK bit and sample it on scl rise.
//   Master ACK (0) -> next byte. Master NACK (1) -> WAIT_STOP (sda released).
// - Register write commits on the 8th scl rise of a data byte, so an aborted byte leaves registers unchanged.
// - Clock stretching (STRETCH_CYCLES > 0): on the scl fall ending each ACK/NACK slot, drive scl 0 for STRETCH_CYCLES cycles, then release.
// - After releasing scl, wait until scl reads high before counting the next bit.
// - Data is never driven during scl high except via the ACK-slot timing above.
// - sda/scl inputs reading x are treated as 1 (pull-up semantics).
// - Reset mid-transaction releases the bus immediately; the next valid START restarts the protocol cleanly.
// TESTING
// - Reset: reset_n=0 -> sda and scl read 1 (released), all regs 00.
// - Write: START, 0x78 (3C<<1|W) ACK, ptr 0x02 ACK, 0xA5 ACK, 0x5A ACK, STOP -> reg[2]=A5, reg[3]=5A.
// - Read: START, 0x78, 0x02, Sr, 0x79 -> reads A5 (master ACK), 5A (master NACK); slave releases sda, STOP -> IDLE.
// - Wrong address: START, 0x7A -> no ACK (sda stays 1 in slot 9); following bytes ignored; regs unchanged.
// - Wrap: ptr 0x0F, write 0x11, 0x22 -> reg[15]=11, reg[0]=22; read from 0x0F also wraps.
// - Stretch: STRETCH_CYCLES=20 -> scl held 0 for 20 cycles after each ACK; master sees scl low when released.
// - Abort: STOP mid-data-byte -> byte discarded, IDLE.

Source files
------------

// File: rtl/i2c_if.sv
// Open-drain I2C bus between one master and one target.
// Each side can only request a pull-down; the line reads 1 when nobody pulls (tri1 pull-up).
interface i2c_if;
    logic sda_dut_low;
    logic scl_dut_low;
    logic sda_mst_low;
    logic scl_mst_low;
    logic sda;
    logic scl;

    // Wired-AND of all pull-down requests: a driver contributes either 0 or z, never 1.
    assign sda = ~(sda_dut_low | sda_mst_low);
    assign scl = ~(scl_dut_low | scl_mst_low);

    modport master (input sda, input scl, output sda_mst_low, output scl_mst_low);
    modport slave  (input sda, input scl, output sda_dut_low, output scl_dut_low);
    modport dut    (input sda, input scl, output sda_dut_low, output scl_dut_low);
endinterface

// File: rtl/i2c_dut.sv
// I2C target serving a byte register file: oversamples sda/scl on system_clock,
// auto-incrementing pointer, optional clock stretching after every ACK/NACK slot.
module i2c_dut #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h3C,
    parameter int         NUM_REGS       = 16,
    parameter int         STRETCH_CYCLES = 0
) (
    input  logic       system_clock,
    input  logic       reset_n,
    i2c_if.dut         bus,
    output logic [2:0] dbg_state
);

    localparam int          PW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [15:0] STRETCH_LEN = 16'(STRETCH_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        PTR       = 3'd2,
        WDATA     = 3'd3,
        RDATA     = 3'd4,
        IGNORE    = 3'd5,
        WAIT_STOP = 3'd6
    } state_t;

    state_t          state;
    logic [3:0]      bit_cnt;
    logic [6:0]      shreg;
    logic [7:0]      tx_byte;
    logic [PW-1:0]   ptr;
    logic            rw;
    logic            mack;
    logic            sda_low;
    logic            scl_low;
    logic [15:0]     stretch_cnt;
    logic [7:0]      regs [NUM_REGS];

    logic [1:0] sda_sync;
    logic [1:0] scl_sync;
    logic       sda_d;
    logic       scl_d;
    logic       sda_in;
    logic       scl_in;
    logic       sda_s;
    logic       scl_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;

    // Anything other than a solid 0 counts as the pulled-up level.
    assign sda_in = (bus.sda !== 1'b0);
    assign scl_in = (bus.scl !== 1'b0);

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
            sda_d    <= 1'b1;
            scl_d    <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
            scl_sync <= {scl_sync[0], scl_in};
            sda_d    <= sda_sync[1];
            scl_d    <= scl_sync[1];
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_s     = scl_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shreg, sda_s};

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shreg       <= 7'd0;
            tx_byte     <= 8'h00;
            ptr         <= '0;
            rw          <= 1'b0;
            mack        <= 1'b1;
            sda_low     <= 1'b0;
            scl_low     <= 1'b0;
            stretch_cnt <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (scl_low) begin
                if (stretch_cnt == 16'd1) begin
                    scl_low     <= 1'b0;
                    stretch_cnt <= 16'd0;
                end else begin
                    stretch_cnt <= stretch_cnt - 16'd1;
                end
            end

            if (start_det) begin
                state       <= ADDR;
                bit_cnt     <= 4'd0;
                sda_low     <= 1'b0;
                scl_low     <= 1'b0;
                stretch_cnt <= 16'd0;
            end else if (stop_det) begin
                state       <= IDLE;
                bit_cnt     <= 4'd0;
                sda_low     <= 1'b0;
                scl_low     <= 1'b0;
                stretch_cnt <= 16'd0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                shreg   <= rx_byte[6:0];
                                bit_cnt <= bit_cnt + 4'd1;
                                // Byte completes on the 8th rise; a write commits only here.
                                if (bit_cnt == 4'd7) begin
                                    if (state == ADDR) begin
                                        if (rx_byte[7:1] != SLAVE_ADDR) state <= IGNORE;
                                        else rw <= rx_byte[0];
                                    end else if (state == PTR) begin
                                        ptr <= rx_byte[PW-1:0];
                                    end else begin
                                        regs[ptr] <= rx_byte;
                                        ptr       <= ptr + 1'b1;
                                    end
                                end
                            end else begin
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b1;
                            end else if (bit_cnt == 4'd9) begin
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (STRETCH_LEN != 16'd0) begin
                                    scl_low     <= 1'b1;
                                    stretch_cnt <= STRETCH_LEN;
                                end
                                if (state == ADDR) begin
                                    if (rw) begin
                                        state   <= RDATA;
                                        tx_byte <= regs[ptr];
                                        sda_low <= ~regs[ptr][7];
                                    end else begin
                                        state <= PTR;
                                    end
                                end else if (state == PTR) begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end

                    RDATA: begin
                        if (scl_rise) begin
                            if (bit_cnt < 4'd8) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                mack    <= sda_s;
                                bit_cnt <= 4'd9;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                ptr     <= ptr + 1'b1;
                            end else if (bit_cnt == 4'd9) begin
                                bit_cnt <= 4'd0;
                                if (STRETCH_LEN != 16'd0) begin
                                    scl_low     <= 1'b1;
                                    stretch_cnt <= STRETCH_LEN;
                                end
                                if (mack) begin
                                    state   <= WAIT_STOP;
                                    sda_low <= 1'b0;
                                end else begin
                                    tx_byte <= regs[ptr];
                                    sda_low <= ~regs[ptr][7];
                                end
                            end else if (bit_cnt != 4'd0) begin
                                sda_low <= ~tx_byte[6];
                                tx_byte <= {tx_byte[6:0], 1'b0};
                            end
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_dut_low = sda_low;
    assign bus.scl_dut_low = scl_low;
    assign dbg_state       = state;

endmodule

// File: tb/tb_i2c_dut.sv
// Directed bench for i2c_dut: a bus-master model drives two targets in lockstep,
// one without and one with clock stretching (20 cycles).
module tb_i2c_dut;
    localparam int         Q           = 6;
    localparam int         STRETCH     = 20;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_IGNORE    = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       mst_sda_low = 1'b0;
    logic       mst_scl_low = 1'b0;
    logic       bus_sel     = 1'b0;
    logic [2:0] st0;
    logic [2:0] st1;

    i2c_if bus0 ();
    i2c_if bus1 ();
    assign bus0.sda_mst_low = mst_sda_low;
    assign bus0.scl_mst_low = mst_scl_low;
    assign bus1.sda_mst_low = mst_sda_low;
    assign bus1.scl_mst_low = mst_scl_low;

    i2c_dut #(.SLAVE_ADDR(7'h3C), .NUM_REGS(16), .STRETCH_CYCLES(0)) dut0 (
        .system_clock(clk), .reset_n(reset_n), .bus(bus0), .dbg_state(st0));
    i2c_dut #(.SLAVE_ADDR(7'h3C), .NUM_REGS(16), .STRETCH_CYCLES(STRETCH)) dut1 (
        .system_clock(clk), .reset_n(reset_n), .bus(bus1), .dbg_state(st1));

    int tests_run    = 0;
    int tests_failed = 0;
    int timeouts     = 0;
    int saw_low1     = 0;
    int run1         = 0;
    int runs1        = 0;
    int bad_runs1    = 0;
    int low0_cycles  = 0;

    logic [7:0] model [16];
    logic [7:0] exp_q [$];

    // Length of every stretch pulse on the stretching target, and any pulse at all on the other.
    always @(negedge clk) begin
        if (bus1.scl_dut_low === 1'b1) begin
            run1 = run1 + 1;
        end else if (run1 != 0) begin
            runs1 = runs1 + 1;
            if (run1 != STRETCH) bad_runs1 = bad_runs1 + 1;
            run1 = 0;
        end
        if (bus0.scl_dut_low === 1'b1) low0_cycles = low0_cycles + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_scl();
        int n;
        mst_scl_low = 1'b0;
        #1;
        if (bus1.scl === 1'b0) saw_low1++;
        n = 0;
        while (!(bus0.scl === 1'b1 && bus1.scl === 1'b1) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) timeouts++;
    endtask

    task automatic bus_bit(input logic b, output logic rd);
        wait_clk(Q);
        mst_sda_low = ~b;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        rd = ((bus_sel ? bus1.sda : bus0.sda) === 1'b1);
        wait_clk(Q);
        mst_scl_low = 1'b1;
    endtask

    task automatic bus_start();
        mst_sda_low = 1'b0;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        mst_sda_low = 1'b1;
        wait_clk(Q);
        mst_scl_low = 1'b1;
    endtask

    task automatic bus_stop();
        mst_sda_low = 1'b1;
        wait_clk(Q);
        release_scl();
        wait_clk(Q);
        mst_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], d);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic d;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, v[i]);
        bus_bit(mack, d);
    endtask

    task automatic write_regs(input logic [7:0] p, input logic [7:0] d0,
                              input logic [7:0] d1, input int n);
        logic ack;
        bus_start();
        send_byte(8'h78, ack); check("wr_addr_ack", ack, 1'b0);
        send_byte(p, ack);     check("wr_ptr_ack", ack, 1'b0);
        send_byte(d0, ack);    check("wr_d0_ack", ack, 1'b0);
        model[p[3:0]] = d0;
        if (n > 1) begin
            send_byte(d1, ack); check("wr_d1_ack", ack, 1'b0);
            model[p[3:0] + 4'd1] = d1;
        end
        bus_stop();
        check("wr_idle", st0, S_IDLE);
    endtask

    task automatic read_regs(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] v;
        logic [3:0] idx;
        bus_start();
        send_byte(8'h78, ack); check("rd_addr_w_ack", ack, 1'b0);
        send_byte(p, ack);     check("rd_ptr_ack", ack, 1'b0);
        bus_start();
        send_byte(8'h79, ack); check("rd_addr_r_ack", ack, 1'b0);
        idx = p[3:0];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model[idx]);
            idx = idx + 4'd1;
        end
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, v);
            check($sformatf("rd_data_%0h_%0d", p, k), v, exp_q.pop_front());
        end
        wait_clk(Q);
        check("rd_sda_released", (bus_sel ? bus1.sda : bus0.sda), 1'b1);
        check("rd_wait_stop", (bus_sel ? st1 : st0), S_WAIT_STOP);
        bus_stop();
        check("rd_idle", (bus_sel ? st1 : st0), S_IDLE);
    endtask

    initial begin
        logic       ack;
        logic       d;
        logic [7:0] v;
        int         runs_before, bad_before, saw_before, low0_before;

        for (int i = 0; i < 16; i++) model[i] = 8'h00;

        // Reset: bus released, FSM idle
        wait_clk(5);
        check("rst_sda0", bus0.sda, 1'b1);
        check("rst_scl0", bus0.scl, 1'b1);
        check("rst_sda1", bus1.sda, 1'b1);
        check("rst_scl1", bus1.scl, 1'b1);
        check("rst_state", st0, S_IDLE);
        reset_n = 1'b1;
        wait_clk(5);
        read_regs(8'h00, 16);

        // Write two bytes from pointer 2, then read them back
        write_regs(8'h02, 8'hA5, 8'h5A, 2);
        read_regs(8'h02, 2);

        // Wrong address: no ACK, following bytes ignored
        bus_start();
        send_byte(8'h7A, ack); check("bad_addr_nack", ack, 1'b1);
        check("bad_addr_ignore", st0, S_IGNORE);
        send_byte(8'h00, ack); check("bad_ptr_nack", ack, 1'b1);
        send_byte(8'hFF, ack); check("bad_data_nack", ack, 1'b1);
        bus_stop();
        check("bad_idle", st0, S_IDLE);
        read_regs(8'h00, 4);

        // Pointer wrap on write and read
        write_regs(8'h0F, 8'h11, 8'h22, 2);
        read_regs(8'h0F, 3);

        // Clock stretching on the second target only
        runs_before = runs1;
        bad_before  = bad_runs1;
        saw_before  = saw_low1;
        low0_before = low0_cycles;
        write_regs(8'h05, 8'h33, 8'h00, 1);
        check("stretch_count", runs1 - runs_before, 3);
        check("stretch_len_bad", bad_runs1 - bad_before, 0);
        check("stretch_seen_by_master", saw_low1 - saw_before, 3);
        check("no_stretch_dut0", low0_cycles - low0_before, 0);
        check("stretch_idle1", st1, S_IDLE);
        bus_sel = 1'b1;
        read_regs(8'h05, 1);
        bus_sel = 1'b0;

        // STOP in the middle of a data byte discards it
        bus_start();
        send_byte(8'h78, ack); check("abort_addr_ack", ack, 1'b0);
        send_byte(8'h06, ack); check("abort_ptr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, d);
        bus_stop();
        check("abort_idle", st0, S_IDLE);
        read_regs(8'h06, 1);

        // Repeated START in the middle of a data byte
        bus_start();
        send_byte(8'h78, ack); check("sr_addr_ack", ack, 1'b0);
        send_byte(8'h07, ack); check("sr_ptr_ack", ack, 1'b0);
        for (int i = 0; i < 5; i++) bus_bit(1'b1, d);
        bus_start();
        check("sr_state_addr", st0, S_ADDR);
        send_byte(8'h79, ack); check("sr_rd_ack", ack, 1'b0);
        read_byte(1'b1, v);
        check("sr_rd_data", v, model[7]);
        bus_stop();

        // Reset during the target's ACK slot
        bus_start();
        send_byte(8'h78, ack); check("mid_addr_ack", ack, 1'b0);
        send_byte(8'h08, ack); check("mid_ptr_ack", ack, 1'b0);
        for (int i = 7; i >= 0; i--) bus_bit(v_c3(i), d);
        wait_clk(Q);
        check("mid_ack_driven", bus0.sda, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_sda", bus0.sda, 1'b1);
        check("mid_rst_state", st0, S_IDLE);
        mst_sda_low = 1'b0;
        wait_clk(Q);
        mst_scl_low = 1'b0;
        wait_clk(Q);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        wait_clk(Q);
        write_regs(8'h08, 8'h99, 8'h00, 1);
        read_regs(8'h08, 1);
        read_regs(8'h02, 1);

        check("bus_timeout", timeouts, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    function automatic logic v_c3(input int i);
        logic [7:0] c;
        c = 8'hC3;
        return c[i];
    endfunction

endmodule
